// File: rtl/mem_access_unit.sv
// Multicycle memory sequencer: arbitrates fetch/load/store into single accesses
// of the unified memory and holds the PC, IR and MDR.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int RESET_PC   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic                  load_req,
  input  logic                  store_req,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [DATA_WIDTH-1:0] mdr,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_FETCH, OP_LOAD, OP_STORE} op_t;

  state_t                state;
  op_t                   op;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      op        <= OP_NONE;
      pc        <= ADDR_WIDTH'(RESET_PC);
      ir        <= '0;
      mdr       <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A PC overwrite wins the cycle; any request alongside it is dropped.
          if (pc_load) begin
            pc <= pc_in;
          end else if (fetch_req || load_req || store_req) begin
            if (fetch_req)     op <= OP_FETCH;
            else if (load_req) op <= OP_LOAD;
            else               op <= OP_STORE;
            addr_reg  <= fetch_req ? pc : addr_in;
            wdata_reg <= data_in;
            state     <= ACCESS;
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          case (op)
            OP_FETCH: begin
              ir <= mem_data_in;
              pc <= pc + 1'b1;
            end
            OP_LOAD: mdr <= mem_data_in;
            default: ;
          endcase
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          op    <= OP_NONE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Reset gates the write combinationally so an interrupted store never lands.
  assign mem_address      = (state == ACCESS) ? addr_reg : pc;
  assign mem_write_enable = (state == ACCESS) && (op == OP_STORE) && !reset;
  assign mem_data_out     = wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit against a transaction-level
// model of PC/IR/MDR and memory contents.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req, load_req, store_req, pc_load;
  logic [7:0]  addr_in, pc_in;
  logic [15:0] data_in;
  logic        busy, done, mem_write_enable;
  logic [7:0]  pc, mem_address;
  logic [15:0] ir, mdr, mem_data_out, mem_data_in;

  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];
  logic [7:0]  ref_pc;
  logic [15:0] ref_ir, ref_mdr;
  int          wr_count = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clock = ~clock;

  mem_access_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .RESET_PC(0)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .load_req(load_req), .store_req(store_req),
    .addr_in(addr_in), .data_in(data_in), .pc_load(pc_load), .pc_in(pc_in),
    .busy(busy), .done(done), .pc(pc), .ir(ir), .mdr(mdr),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
  );

  assign mem_data_in = mem[mem_address];
  always @(posedge clock) if (mem_write_enable) begin
    mem[mem_address] <= mem_data_out;
    wr_count         <= wr_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock); #1;
  endtask

  task automatic clear_inputs();
    fetch_req = 0; load_req = 0; store_req = 0; pc_load = 0;
  endtask

  // One complete request through IDLE -> ACCESS -> DONE -> IDLE.
  task automatic do_op(input logic f, input logic l, input logic s,
                       input logic [7:0] a, input logic [15:0] d, input string tag);
    int         kind;
    int         wr0;
    logic [7:0] exp_addr;
    kind = f ? 1 : (l ? 2 : (s ? 3 : 0));
    exp_addr = (kind == 1) ? ref_pc : a;
    wr0 = wr_count;
    fetch_req = f; load_req = l; store_req = s; addr_in = a; data_in = d;
    cycle();
    clear_inputs();
    chk({tag, ".acc_busy"}, 32'(busy), 32'(1));
    chk({tag, ".acc_done"}, 32'(done), 32'(0));
    chk({tag, ".acc_addr"}, 32'(mem_address), 32'(exp_addr));
    chk({tag, ".acc_we"}, 32'(mem_write_enable), 32'(kind == 3));
    if (kind == 3) chk({tag, ".acc_wdata"}, 32'(mem_data_out), 32'(d));
    addr_in = ~a; data_in = ~d; #1;
    chk({tag, ".acc_addr_hold"}, 32'(mem_address), 32'(exp_addr));
    case (kind)
      1: begin ref_ir = ref_mem[ref_pc]; ref_pc = ref_pc + 8'd1; end
      2: ref_mdr = ref_mem[a];
      3: ref_mem[a] = d;
      default: ;
    endcase
    cycle();
    chk({tag, ".done"}, 32'(done), 32'(1));
    chk({tag, ".done_busy"}, 32'(busy), 32'(1));
    chk({tag, ".ir"}, 32'(ir), 32'(ref_ir));
    chk({tag, ".mdr"}, 32'(mdr), 32'(ref_mdr));
    chk({tag, ".pc"}, 32'(pc), 32'(ref_pc));
    chk({tag, ".writes"}, 32'(wr_count - wr0), 32'(kind == 3));
    cycle();
    chk({tag, ".idle_busy"}, 32'(busy), 32'(0));
    chk({tag, ".idle_done"}, 32'(done), 32'(0));
  endtask

  initial begin
    int          dones, wr0, bad;
    logic [7:0]  a, old_pc;
    logic [15:0] d, keep;
    logic [2:0]  r;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
    end
    mem[0] = 16'h3406; mem[1] = 16'h3807;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    clear_inputs(); addr_in = 0; data_in = 0; pc_in = 0;
    reset = 1;
    cycle(); cycle();
    reset = 0;
    ref_pc = 0; ref_ir = 0; ref_mdr = 0;
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.pc", 32'(pc), 0);
    chk("rst.ir", 32'(ir), 0);
    chk("rst.mdr", 32'(mdr), 0);
    chk("rst.we", 32'(mem_write_enable), 0);
    chk("rst.addr", 32'(mem_address), 0);

    // Two fetches from the preloaded program.
    do_op(1, 0, 0, 8'h00, 16'h0, "fetch0");
    chk("fetch0.ir_const", 32'(ir), 32'h3406);
    do_op(1, 0, 0, 8'h00, 16'h0, "fetch1");
    chk("fetch1.ir_const", 32'(ir), 32'h3807);
    chk("fetch1.pc_const", 32'(pc), 32'd2);

    // Store then load back the same address.
    keep = ref_ir;
    do_op(0, 0, 1, 8'h20, 16'hBEEF, "store20");
    do_op(0, 1, 0, 8'h20, 16'h0, "load20");
    chk("load20.mdr_const", 32'(mdr), 32'hBEEF);
    chk("load20.ir_keep", 32'(ir), 32'(keep));

    // All three together: only the fetch runs.
    do_op(1, 1, 1, 8'h30, 16'h1234, "prio");

    // PC wrap from 0xFF.
    pc_load = 1; pc_in = 8'hFF;
    cycle(); clear_inputs(); ref_pc = 8'hFF;
    chk("pcload.pc", 32'(pc), 32'hFF);
    do_op(1, 0, 0, 8'h00, 16'h0, "wrap");
    chk("wrap.pc_zero", 32'(pc), 0);

    // pc_load with fetch: PC overwrite only, no access.
    a = 8'($urandom); wr0 = wr_count;
    pc_load = 1; fetch_req = 1; pc_in = a;
    cycle(); clear_inputs(); ref_pc = a;
    chk("pcl_fetch.pc", 32'(pc), 32'(a));
    chk("pcl_fetch.busy", 32'(busy), 0);
    cycle();
    chk("pcl_fetch.done", 32'(done), 0);
    chk("pcl_fetch.busy2", 32'(busy), 0);
    chk("pcl_fetch.writes", 32'(wr_count - wr0), 0);

    // Reset during a store's access cycle.
    keep = mem[8'h10]; wr0 = wr_count;
    store_req = 1; addr_in = 8'h10; data_in = ~keep;
    cycle(); clear_inputs();
    reset = 1; #1;
    chk("rstmid.we", 32'(mem_write_enable), 0);
    cycle(); reset = 0; #1;
    ref_pc = 0; ref_ir = 0; ref_mdr = 0;
    chk("rstmid.busy", 32'(busy), 0);
    chk("rstmid.done", 32'(done), 0);
    chk("rstmid.pc", 32'(pc), 0);
    chk("rstmid.ir", 32'(ir), 0);
    chk("rstmid.mdr", 32'(mdr), 0);
    cycle();
    chk("rstmid.done2", 32'(done), 0);
    chk("rstmid.mem", 32'(mem[8'h10]), 32'(keep));
    chk("rstmid.writes", 32'(wr_count - wr0), 0);

    // Load held high: one operation per three cycles.
    a = 8'($urandom); dones = 0;
    load_req = 1; addr_in = a;
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (busy && !done) chk("hold.acc_addr", 32'(mem_address), 32'(a));
      addr_in = ~a;
      #1;
      if (busy && !done) chk("hold.acc_addr_tog", 32'(mem_address), 32'(a));
      addr_in = a;
      if (done) dones++;
    end
    clear_inputs();
    ref_mdr = ref_mem[a];
    chk("hold.dones", 32'(dones), 3);
    chk("hold.mdr", 32'(mdr), 32'(ref_mdr));
    cycle(); cycle();
    chk("hold.idle", 32'(busy), 0);

    // Randomized mix of requests and PC overwrites.
    for (int i = 0; i < 40; i++) begin
      r = 3'($urandom_range(1, 7));
      a = 8'($urandom); d = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        old_pc = 8'($urandom);
        pc_load = 1; pc_in = old_pc;
        cycle(); clear_inputs(); ref_pc = old_pc;
        chk("rnd.pcload", 32'(pc), 32'(ref_pc));
      end
      do_op(r[2], r[1], r[0], a, d, "rnd");
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("final.mem_image", 32'(bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Multicycle memory sequencer between the CPU control FSM/datapath and the unified 256x16 combined memory. Arbitrates instruction fetch, data load and data store into single memory accesses. Holds the PC, instruction register (IR) and memory data register (MDR). Drives the memory's address, write-enable and write-data; consumes its combinational read data.

Parameters:
ADDR_WIDTH, 8, memory address width; PC width.
DATA_WIDTH, 16, memory word width.
RESET_PC, 0, PC value after reset.

Ports:
clock  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
fetch_req  input  1  request: IR <= mem[PC], then PC <= PC+1.
load_req  input  1  request: MDR <= mem[addr_in].
store_req  input  1  request: mem[addr_in] <= data_in.
addr_in  input  ADDR_WIDTH  load/store address from the datapath.
data_in  input  DATA_WIDTH  store data from the datapath.
pc_load  input  1  overwrite PC with pc_in (branch/jump).
pc_in  input  ADDR_WIDTH  new PC value.
busy  output  1  high while not IDLE.
done  output  1  one-cycle pulse when an operation completes.
pc  output  ADDR_WIDTH  current PC.
ir  output  DATA_WIDTH  instruction register.
mdr  output  DATA_WIDTH  memory data register.
mem_address  output  ADDR_WIDTH  to memory address.
mem_write_enable  output  1  to memory write_enable.
mem_data_out  output  DATA_WIDTH  to memory A_in.
mem_data_in  input  DATA_WIDTH  from memory A_out; combinational read of mem_address.

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, ir=0, mdr=0, op=NONE, addr_reg=0, wdata_reg=0. busy=0, done=0, mem_write_enable=0. Memory contents are not reset.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE: busy=0.
  - pc_load=1: pc<=pc_in; any request in the same cycle is dropped and must be re-asserted.
  - Otherwise, requests are accepted with priority fetch > load > store. Only the highest is taken; lower ones are dropped. On accept: op latched; addr_reg<=pc for fetch, else addr_in; wdata_reg<=data_in; go ACCESS.
- ACCESS: busy=1; mem_address=addr_reg; mem_data_out=wdata_reg.
  - mem_write_enable = (op==STORE) && !reset; exactly one write cycle per store.
  - At the posedge: fetch ir<=mem_data_in and pc<=pc+1 (mod 2^ADDR_WIDTH, 255->0); load mdr<=mem_data_in; store leaves ir/mdr unchanged. Go DONE.
- DONE: busy=1, done=1 for exactly one cycle; ir/mdr hold final values. Next state IDLE.
- Latency: request sampled at edge k; access during cycle k+1; done high during cycle k+2; next request accepted at the edge ending cycle k+3 (IDLE). Back-to-back throughput: one operation per 3 cycles.
- Outside ACCESS: mem_address=pc, mem_write_enable=0, mem_data_out=wdata_reg.
- Requests and pc_load while busy=1 are ignored; no queueing.
- Reset mid-operation: reset high during ACCESS suppresses the write that cycle. State returns to IDLE, done is not pulsed, and pc/ir/mdr take reset values.
- Addresses are unsigned with no bounds error; the full 0..255 range is legal.

Test Plan:
1. Memory preloaded mem[0]=16'h3406, mem[1]=16'h3807. After reset pulse fetch_req twice -> ir=16'h3406 then 16'h3807 at each done; pc 0->1->2; busy high 2 cycles per op.
2. store_req addr_in=8'h20, data_in=16'hBEEF, then load_req addr_in=8'h20 -> exactly one mem_write_enable cycle with mem_address=8'h20; mdr=16'hBEEF at done; ir unchanged.
3. fetch_req, load_req and store_req asserted together in IDLE -> only fetch performed; no write occurs; pc increments by 1.
4. pc_load with pc_in=8'hFF, then fetch_req -> ir=mem[255] and pc wraps to 8'h00. pc_load and fetch_req together -> pc=pc_in, no access, done stays 0.
5. store_req to 8'h10 with reset asserted during ACCESS -> mem[8'h10] unchanged; state IDLE; pc=0; no done pulse.
6. Assert load_req continuously while busy -> exactly one access per 3-cycle window. Toggling addr_in during ACCESS does not change mem_address.
